capture_cmd_sequencer: RTL and testbench

CAPTURE_CMD_SEQUENCER -- requirements
Module: capture_cmd_sequencer

---
 rtl/capture_cmd_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_capture_cmd_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/capture_cmd_sequencer.sv
// Host-side sequencer for a logic-analyzer capture core: turns host operations into
// strobed command/ACK handshakes on the core's command bus, with startup delay and ack timeout.
module capture_cmd_sequencer #(
    parameter int STARTUP_DELAY_CLKS = 50,
    parameter int ACK_TIMEOUT_CLKS   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] pre_trigger_count,
    input  logic [31:0] total_sample_count,
    output logic        req_ready,
    output logic        done,
    output logic        error,
    output logic [31:0] result,
    output logic [7:0]  command,
    output logic        commandStrobe,
    output logic [7:0]  regIn0,
    output logic [7:0]  regIn1,
    output logic [7:0]  regIn2,
    output logic [7:0]  regIn3,
    output logic [7:0]  regIn4,
    output logic [7:0]  regIn5,
    output logic [7:0]  regIn6,
    output logic [7:0]  regIn7,
    input  logic [7:0]  regOut0,
    input  logic [7:0]  regOut1,
    input  logic [7:0]  regOut2,
    input  logic [7:0]  regOut3,
    input  logic [7:0]  status
);
    // Counter widths leave headroom so the "+1" compare never wraps.
    localparam int SW = $clog2(STARTUP_DELAY_CLKS + 2);
    localparam int TW = $clog2(ACK_TIMEOUT_CLKS + 2);

    localparam logic [7:0] CMD_NOP        = 8'h00;
    localparam logic [7:0] CMD_START      = 8'h01;
    localparam logic [7:0] CMD_ABORT      = 8'h02;
    localparam logic [7:0] CMD_BUF_CFG    = 8'h04;
    localparam logic [7:0] CMD_READ_SIZE  = 8'h06;
    localparam logic [7:0] CMD_ACK        = 8'h08;
    localparam logic [7:0] CMD_READ_TRIG  = 8'h10;

    localparam logic [1:0] OP_CONFIG_START = 2'd0;
    localparam logic [1:0] OP_ABORT        = 2'd1;
    localparam logic [1:0] OP_READ_SIZE    = 2'd2;
    localparam logic [1:0] OP_READ_TRIG    = 2'd3;

    typedef enum logic [3:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_LOAD,
        ST_STROBE,
        ST_WAIT_ACK,
        ST_SEND_ACK,
        ST_WAIT_CLR,
        ST_FINISH,
        ST_FAIL
    } state_t;

    state_t         r_state;
    logic [SW-1:0]  r_startup_cnt;
    logic [TW-1:0]  r_tmo_cnt;
    logic [1:0]     r_op;
    logic           r_step;
    logic [7:0]     r_command;
    logic           r_strobe;
    logic [31:0]    r_total;
    logic [31:0]    r_pre;
    logic [31:0]    r_result;
    logic           r_ready;
    logic           r_done;
    logic           r_error;

    logic [SW-1:0]  w_startup_nxt;
    logic           w_startup_done;
    logic [TW-1:0]  w_tmo_nxt;
    logic           w_tmo_expired;
    logic           w_accept;
    logic           w_cfg_bad;
    logic           w_ack;
    logic           w_is_read;
    logic           w_more;
    logic [7:0]     w_first_cmd;
    logic           w_unused_status;

    assign w_startup_nxt   = r_startup_cnt + 1'b1;
    assign w_startup_done  = (w_startup_nxt >= SW'(STARTUP_DELAY_CLKS));
    assign w_tmo_nxt       = r_tmo_cnt + 1'b1;
    assign w_tmo_expired   = (w_tmo_nxt >= TW'(ACK_TIMEOUT_CLKS));
    assign w_accept        = req_valid && r_ready;
    assign w_cfg_bad       = (total_sample_count == 32'd0) || (total_sample_count < pre_trigger_count);
    assign w_ack           = status[3];
    assign w_is_read       = (r_op == OP_READ_SIZE) || (r_op == OP_READ_TRIG);
    // Only CONFIG_START has a second command (START) after BUFFER_CONFIGURE.
    assign w_more          = (r_op == OP_CONFIG_START) && !r_step;
    assign w_unused_status = ^{status[7:4], status[2:0]};

    always_comb begin
        w_first_cmd = CMD_NOP;
        case (req_op)
            OP_CONFIG_START: w_first_cmd = CMD_BUF_CFG;
            OP_ABORT:        w_first_cmd = CMD_ABORT;
            OP_READ_SIZE:    w_first_cmd = CMD_READ_SIZE;
            OP_READ_TRIG:    w_first_cmd = CMD_READ_TRIG;
            default:         w_first_cmd = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_STARTUP;
            r_startup_cnt <= '0;
            r_tmo_cnt     <= '0;
            r_op          <= OP_CONFIG_START;
            r_step        <= 1'b0;
            r_command     <= CMD_NOP;
            r_strobe      <= 1'b0;
            r_total       <= 32'd0;
            r_pre         <= 32'd0;
            r_result      <= 32'd0;
            r_ready       <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            case (r_state)
                ST_STARTUP: begin
                    r_startup_cnt <= w_startup_nxt;
                    if (w_startup_done) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_op    <= req_op;
                        r_step  <= 1'b0;
                        if (req_op == OP_CONFIG_START && w_cfg_bad) begin
                            r_state   <= ST_FAIL;
                            r_error   <= 1'b1;
                            r_command <= CMD_NOP;
                        end else begin
                            if (req_op == OP_CONFIG_START) begin
                                r_total <= total_sample_count;
                                r_pre   <= pre_trigger_count;
                            end
                            r_command <= w_first_cmd;
                            r_state   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    r_strobe <= 1'b1;
                    r_state  <= ST_STROBE;
                end
                ST_STROBE: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (w_ack) begin
                        if (w_is_read)
                            r_result <= {regOut3, regOut2, regOut1, regOut0};
                        r_command <= CMD_ACK;
                        r_strobe  <= 1'b1;
                        r_state   <= ST_SEND_ACK;
                    end else if (w_tmo_expired) begin
                        r_command <= CMD_NOP;
                        r_error   <= 1'b1;
                        r_state   <= ST_FAIL;
                    end else begin
                        r_tmo_cnt <= w_tmo_nxt;
                    end
                end
                ST_SEND_ACK: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT_CLR;
                end
                ST_WAIT_CLR: begin
                    if (!w_ack) begin
                        if (w_more) begin
                            r_step    <= 1'b1;
                            r_command <= CMD_START;
                            r_state   <= ST_LOAD;
                        end else begin
                            r_command <= CMD_NOP;
                            r_done    <= 1'b1;
                            r_state   <= ST_FINISH;
                        end
                    end else if (w_tmo_expired) begin
                        r_command <= CMD_NOP;
                        r_error   <= 1'b1;
                        r_state   <= ST_FAIL;
                    end else begin
                        r_tmo_cnt <= w_tmo_nxt;
                    end
                end
                ST_FINISH, ST_FAIL: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_command <= CMD_NOP;
                    r_state   <= ST_IDLE;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = r_ready;
    assign done          = r_done;
    assign error         = r_error;
    assign result        = r_result;
    assign command       = r_command;
    assign commandStrobe = r_strobe;
    assign regIn0        = r_total[7:0];
    assign regIn1        = r_total[15:8];
    assign regIn2        = r_total[23:16];
    assign regIn3        = r_total[31:24];
    assign regIn4        = r_pre[7:0];
    assign regIn5        = r_pre[15:8];
    assign regIn6        = r_pre[23:16];
    assign regIn7        = r_pre[31:24];

endmodule

// File: tb/tb_capture_cmd_sequencer.sv
// Bench for capture_cmd_sequencer: table of host operations against a small capture-core
// responder, plus hand sequences for startup, timeout and mid-sequence reset.
`timescale 1ns/1ps
module tb_capture_cmd_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] pre_trigger_count, total_sample_count;
    logic        req_ready, done, error;
    logic [31:0] result;
    logic [7:0]  command;
    logic        commandStrobe;
    logic [7:0]  regIn0, regIn1, regIn2, regIn3, regIn4, regIn5, regIn6, regIn7;
    logic [7:0]  regOut0, regOut1, regOut2, regOut3;
    logic [7:0]  status;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    capture_cmd_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op),
        .pre_trigger_count(pre_trigger_count), .total_sample_count(total_sample_count),
        .req_ready(req_ready), .done(done), .error(error), .result(result),
        .command(command), .commandStrobe(commandStrobe),
        .regIn0(regIn0), .regIn1(regIn1), .regIn2(regIn2), .regIn3(regIn3),
        .regIn4(regIn4), .regIn5(regIn5), .regIn6(regIn6), .regIn7(regIn7),
        .regOut0(regOut0), .regOut1(regOut1), .regOut2(regOut2), .regOut3(regOut3),
        .status(status)
    );

    wire [31:0] w_tot = {regIn3, regIn2, regIn1, regIn0};
    wire [31:0] w_pre = {regIn7, regIn6, regIn5, regIn4};

    typedef struct {
        logic [1:0]  op;
        logic [31:0] pre;
        logic [31:0] total;
        logic [31:0] ro;
        int          dly;
        logic [31:0] seq;
        int          nstb;
        int          ndone;
        int          nerr;
        logic [31:0] res;
        logic [31:0] tot;
        logic [31:0] prx;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        check(name, {31'd0, req_ready}, 32'd1);
    endtask

    // Released from reset at posedge+1; ready must rise exactly 50 edges later.
    task automatic startup_check(input string tag);
        int n = 0;
        int stb = 0;
        req_valid = 1'b1;
        req_op    = 2'd2;
        while (!req_ready && n < 200) begin
            tick();
            n++;
            if (commandStrobe) stb++;
        end
        req_valid = 1'b0;
        check({tag, "_ready_latency"}, n, 32'd50);
        check({tag, "_no_strobe"}, stb, 32'd0);
        tick();
        check({tag, "_still_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    // Drives one request and plays the capture core: raise ack dly cycles after a
    // command strobe, drop it on the ACK strobe.
    task automatic run_op(input vec_t v, output logic [31:0] seq, output int nstb,
                          output int ndone, output int nerr, output int evt);
        int  cd;
        bit  fin;
        seq = 32'd0; nstb = 0; ndone = 0; nerr = 0; evt = -1; cd = -1; fin = 1'b0;
        {regOut3, regOut2, regOut1, regOut0} = v.ro;
        req_valid = 1'b1;
        req_op = v.op;
        pre_trigger_count = v.pre;
        total_sample_count = v.total;
        tick();
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (done) ndone++;
            if (error) nerr++;
            if (done || error) begin
                fin = 1'b1;
                evt = cyc;
            end
            if (commandStrobe) begin
                nstb++;
                seq = (seq << 8) | {24'd0, command};
                if (command == 8'h08) status[3] = 1'b0;
                else if (v.dly == 0) status[3] = 1'b1;
                else cd = v.dly;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    status[3] = 1'b1;
                    cd = -1;
                end
            end
            tick();
        end
        if (done) ndone++;
        if (error) nerr++;
    endtask

    initial begin
        logic [31:0] seq;
        int nstb, ndone, nerr, evt, n;
        logic [31:0] res_before;

        //            op    pre     total   regOut        dly seq            n  d  e  result        tot     pre
        vecs[0] = '{2'd0, 32'd20,  32'd110, 32'h0,        3, 32'h04080108, 4, 1, 0, 32'h0,        32'd110, 32'd20};
        vecs[1] = '{2'd2, 32'd0,   32'd0,   32'h12345678, 3, 32'h00000608, 2, 1, 0, 32'h12345678, 32'd110, 32'd20};
        vecs[2] = '{2'd3, 32'd0,   32'd0,   32'hDDCCBBAA, 2, 32'h00001008, 2, 1, 0, 32'hDDCCBBAA, 32'd110, 32'd20};
        vecs[3] = '{2'd1, 32'd0,   32'd0,   32'h11111111, 1, 32'h00000208, 2, 1, 0, 32'hDDCCBBAA, 32'd110, 32'd20};
        vecs[4] = '{2'd0, 32'd200, 32'd100, 32'h0,        3, 32'h00000000, 0, 0, 1, 32'hDDCCBBAA, 32'd110, 32'd20};
        vecs[5] = '{2'd0, 32'd0,   32'd0,   32'h0,        3, 32'h00000000, 0, 0, 1, 32'hDDCCBBAA, 32'd110, 32'd20};
        vecs[6] = '{2'd0, 32'd5,   32'd5,   32'h0,        0, 32'h04080108, 4, 1, 0, 32'hDDCCBBAA, 32'd5,   32'd5};
        vecs[7] = '{2'd2, 32'd0,   32'd0,   32'h04030201, 5, 32'h00000608, 2, 1, 0, 32'h04030201, 32'd5,   32'd5};
        vecs[8] = '{2'd0, 32'd0,   32'd1,   32'h0,        2, 32'h04080108, 4, 1, 0, 32'h04030201, 32'd1,   32'd0};

        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 2'd0;
        pre_trigger_count = 32'd0;
        total_sample_count = 32'd0;
        {regOut3, regOut2, regOut1, regOut0} = 32'd0;
        status = 8'hF7;
        #2;
        check("rst_command", command, 32'h0);
        check("rst_strobe", {31'd0, commandStrobe}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_done_err", {30'd0, done, error}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_regin", w_tot | w_pre, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        startup_check("startup");

        for (int i = 0; i < 9; i++) begin
            wait_ready($sformatf("v%0d_ready", i));
            run_op(vecs[i], seq, nstb, ndone, nerr, evt);
            check($sformatf("v%0d_strobe_seq", i), seq, vecs[i].seq);
            check($sformatf("v%0d_strobe_cnt", i), nstb, vecs[i].nstb);
            check($sformatf("v%0d_done_pulses", i), ndone, vecs[i].ndone);
            check($sformatf("v%0d_error_pulses", i), nerr, vecs[i].nerr);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_regin_total", i), w_tot, vecs[i].tot);
            check($sformatf("v%0d_regin_pre", i), w_pre, vecs[i].prx);
            if (vecs[i].nerr != 0)
                check($sformatf("v%0d_error_latency", i), evt, 32'd0);
        end
        check("cfg_regIn0", {24'd0, regIn0}, 32'h01);

        // Core never acks: error must land 1024 clocks after WAIT_ACK entry.
        wait_ready("tmo_ready0");
        res_before = result;
        {regOut3, regOut2, regOut1, regOut0} = 32'hFFFFFFFF;
        req_valid = 1'b1;
        req_op = 2'd2;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!commandStrobe && n < 10) begin
            tick();
            n++;
        end
        check("tmo_strobe", {31'd0, commandStrobe}, 32'd1);
        n = 0;
        while (!error && n < 1100) begin
            tick();
            n++;
            if (commandStrobe) n = 5000;
        end
        check("tmo_latency", n, 32'd1025);
        check("tmo_command_nop", command, 32'h0);
        check("tmo_result_kept", result, res_before);
        tick();
        check("tmo_back_idle", {30'd0, req_ready, error}, 32'd2);

        // Reset in WAIT_ACK: outputs clear immediately and startup repeats.
        req_valid = 1'b1;
        req_op = 2'd3;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
        check("mid_no_done", {30'd0, done, error}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_command", command, 32'h0);
        check("mid_rst_strobe_ready", {30'd0, commandStrobe, req_ready}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_regin", w_tot | w_pre, 32'd0);
        #1;
        repeat (3) tick();
        reset = 1'b0;
        startup_check("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
